mult_stream_sched: RTL

//  Sequencer/flow controller between the DMA AXI-Stream pair and configurable_multiplication.

---
 rtl/mult_stream_sched_if.sv | 34 +++
 rtl/mult_stream_sched.sv | 119 +++++++++++
 2 files changed

// File: rtl/mult_stream_sched_if.sv
// Signal bundle between mult_stream_sched and its neighbours: operand stream, product stream,
// mode-change request and the multiplier side-band.
interface mult_stream_sched_if;
  logic        s_axis_valid_i;
  logic [31:0] s_axis_data_i;
  logic        s_axis_ready_o;
  logic        m_axis_valid_o;
  logic [31:0] m_axis_data_o;
  logic        m_axis_ready_i;
  logic        cfg_valid_i;
  logic [1:0]  cfg_cm_i;
  logic        cfg_ready_o;
  logic [15:0] multiplicand_o;
  logic [15:0] multiplier_o;
  logic        enable_o;
  logic [1:0]  cm_o;
  logic [31:0] product_i;
  logic        data_valid_i;
  logic [2:0]  err_o;

  modport slave (
    input  s_axis_valid_i, s_axis_data_i, m_axis_ready_i, cfg_valid_i, cfg_cm_i,
           product_i, data_valid_i,
    output s_axis_ready_o, m_axis_valid_o, m_axis_data_o, cfg_ready_o, multiplicand_o,
           multiplier_o, enable_o, cm_o, err_o
  );

  modport master (
    output s_axis_valid_i, s_axis_data_i, m_axis_ready_i, cfg_valid_i, cfg_cm_i,
           product_i, data_valid_i,
    input  s_axis_ready_o, m_axis_valid_o, m_axis_data_o, cfg_ready_o, multiplicand_o,
           multiplier_o, enable_o, cm_o, err_o
  );
endinterface

// File: rtl/mult_stream_sched.sv
// Credit-based issue/return sequencer for the multiplier: enable one cycle after accept, product
// visible one cycle after its strobe; operands stall when credits run out or a mode change drains.
module mult_stream_sched #(
  parameter int         DEPTH    = 4,
  parameter int         TIMEOUT  = 64,
  parameter logic [1:0] CM_RESET = 2'b00
) (
  input logic                 clk_i,
  input logic                 reset_i,
  mult_stream_sched_if.slave  io
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, DRAIN, APPLY} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  out_q, out_d, cnt_q, cnt_d;
  logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic [31:0]    mem_q [DEPTH];
  logic [15:0]    mcand_q, mcand_d, mplier_q, mplier_d;
  logic           en_q, en_d;
  logic [1:0]     cm_q, cm_d;
  logic [2:0]     err_q, err_d;
  logic [CW:0]    used;
  logic           hs, push, pop, spur, tmo;

  assign used = {1'b0, out_q} + {1'b0, cnt_q};
  assign io.s_axis_ready_o = (state_q == RUN) && !io.cfg_valid_i && (used < (CW+1)'(DEPTH));
  assign hs   = io.s_axis_valid_i && io.s_axis_ready_o;
  assign push = io.data_valid_i && (out_q != '0);
  assign spur = io.data_valid_i && (out_q == '0);
  assign pop  = io.m_axis_valid_o && io.m_axis_ready_i;
  assign tmo  = (out_q != '0) && !io.data_valid_i && (tmr_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    tmr_d    = '0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    en_d     = hs;
    cm_d     = cm_q;
    err_d    = err_q | {tmo, 1'b0, spur};

    if (hs) begin
      mcand_d  = io.s_axis_data_i[31:16];
      mplier_d = io.s_axis_data_i[15:0];
    end
    if (hs && !push)      out_d = out_q + CW'(1);
    else if (!hs && push) out_d = out_q - CW'(1);
    // Abandoned ops release their credits; an op accepted this very cycle is still live.
    if (tmo)              out_d = hs ? CW'(1) : '0;

    if (io.data_valid_i == 1'b0 && out_q != '0 && !tmo) tmr_d = tmr_q + TW'(1);

    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
    if (push) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
    if (pop)  rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);

    case (state_q)
      RUN:   if (io.cfg_valid_i) state_d = DRAIN;
      DRAIN: if (out_d == '0) state_d = APPLY;
      APPLY: begin
        state_d = RUN;
        if (io.cfg_cm_i == 2'b11) err_d[1] = 1'b1;
        else                      cm_d     = io.cfg_cm_i;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= RUN;
      out_q    <= '0;
      cnt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      tmr_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      en_q     <= 1'b0;
      cm_q     <= CM_RESET;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      tmr_q    <= tmr_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      en_q     <= en_d;
      cm_q     <= cm_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= io.product_i;
  end

  assign io.m_axis_valid_o = (cnt_q != '0);
  assign io.m_axis_data_o  = io.m_axis_valid_o ? mem_q[rd_q] : '0;
  assign io.cfg_ready_o    = (state_q == APPLY);
  assign io.multiplicand_o = mcand_q;
  assign io.multiplier_o   = mplier_q;
  assign io.enable_o       = en_q;
  assign io.cm_o           = cm_q;
  assign io.err_o          = err_q;
endmodule
